// File: rtl/rv32i_sequencer.sv
// rv32i_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM.
// Owns the PC and retired-instruction counter; drives the shared memory port.
module rv32i_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] inst_class,
    input  logic        branch_taken,
    input  logic [31:0] target,
    input  logic        mem_ready,
    input  logic        mem_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [1:0] C_ILLEGAL = 2'd0;
    localparam logic [1:0] C_ECALL   = 2'd1;
    localparam logic [1:0] C_MEM     = 2'd2;
    localparam logic [1:0] C_ALIGN   = 2'd3;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] instret_nxt;
    logic [1:0]  cause_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] instret_inc;

    logic is_lui;
    logic is_auipc;
    logic is_jal;
    logic is_jalr;
    logic is_branch;
    logic is_load;
    logic is_store;
    logic is_op_imm;
    logic is_op;
    logic is_ecall;
    logic is_ebreak;
    logic one_hot;
    logic taken;
    logic misaligned;

    assign is_lui    = inst_class[0];
    assign is_auipc  = inst_class[1];
    assign is_jal    = inst_class[2];
    assign is_jalr   = inst_class[3];
    assign is_branch = inst_class[4];
    assign is_load   = inst_class[5];
    assign is_store  = inst_class[6];
    assign is_op_imm = inst_class[7];
    assign is_op     = inst_class[8];
    assign is_ecall  = inst_class[10];
    assign is_ebreak = inst_class[11];

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign one_hot = (inst_class != 12'd0)
                   && ((inst_class & (inst_class - 12'd1)) == 12'd0);

    assign taken      = is_jal | is_jalr | (is_branch & branch_taken);
    assign misaligned = taken & (target[1:0] != 2'b00);

    assign pc_plus4    = pc + 32'd4;
    assign instret_inc = instret + 32'd1;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instret_nxt  = instret;
        cause_nxt    = trap_cause;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        halted       = 1'b0;
        trap         = 1'b0;
        // Reset masks every strobe so an in-flight memory request is dropped at once.
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        if (mem_fault) begin
                            state_nxt = S_TRAP;
                            cause_nxt = C_MEM;
                        end else begin
                            ir_we     = 1'b1;
                            state_nxt = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (!one_hot) begin
                        state_nxt = S_TRAP;
                        cause_nxt = C_ILLEGAL;
                    end else if (is_ebreak) begin
                        state_nxt = S_HALT;
                    end else if (is_ecall) begin
                        state_nxt = S_TRAP;
                        cause_nxt = C_ECALL;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_nxt = (is_load | is_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready) begin
                        if (mem_fault) begin
                            state_nxt = S_TRAP;
                            cause_nxt = C_MEM;
                        end else if (is_store) begin
                            pc_nxt      = pc_plus4;
                            instret_nxt = instret_inc;
                            state_nxt   = S_FETCH;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (is_lui) begin
                        wb_sel = 2'd3;
                    end else if (is_jal | is_jalr) begin
                        wb_sel = 2'd2;
                    end else if (is_load) begin
                        wb_sel = 2'd1;
                    end else begin
                        wb_sel = 2'd0;
                    end
                    if (misaligned) begin
                        state_nxt = S_TRAP;
                        cause_nxt = C_ALIGN;
                    end else begin
                        rf_we = is_lui | is_auipc | is_jal | is_jalr
                              | is_op_imm | is_op | is_load;
                        pc_nxt      = taken ? target : pc_plus4;
                        instret_nxt = instret_inc;
                        state_nxt   = S_FETCH;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                S_TRAP: begin
                    trap = 1'b1;
                end
                default: begin
                    state_nxt = S_TRAP;
                    cause_nxt = C_ILLEGAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            instret    <= 32'd0;
            trap_cause <= 2'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            instret    <= instret_nxt;
            trap_cause <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_rv32i_sequencer.sv
// tb_rv32i_sequencer: directed instruction sequences with a scoreboard
// that checks each instruction's observed outcome when it completes.
module tb_rv32i_sequencer;

    typedef struct {
        int          kind;
        int          cyc;
        int          rf;
        logic [1:0]  wbs;
        int          mc;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [1:0]  cause;
    } exp_t;

    localparam int K_RET  = 0;
    localparam int K_TRAP = 1;
    localparam int K_HALT = 2;
    localparam int K_RST  = 3;

    logic        clk;
    logic        rst;
    logic [11:0] inst_class;
    logic        branch_taken;
    logic [31:0] target;
    logic        mem_ready;
    logic        mem_fault;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    rv32i_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .inst_class(inst_class),
        .branch_taken(branch_taken), .target(target),
        .mem_ready(mem_ready), .mem_fault(mem_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc),
        .instret(instret), .halted(halted), .trap(trap),
        .trap_cause(trap_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor state
    bit          active;
    bit          term;
    bit          after_rst;
    int          a_cyc;
    int          a_rf;
    logic [1:0]  a_wbs;
    int          a_mc;
    logic [31:0] fz_pc;

    task automatic close_txn(input int k);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL txn: unexpected completion kind=%0d pc=%h", k, pc);
        end else begin
            e = q.pop_front();
            if (k != e.kind || a_cyc != e.cyc || a_rf != e.rf
                || a_wbs !== e.wbs || a_mc != e.mc || pc !== e.pc
                || instret !== e.ir || trap_cause !== e.cause) begin
                errors++;
                $display("FAIL txn: got kind=%0d cyc=%0d rf=%0d wb=%0d mem=%0d pc=%h ir=%0d cause=%0d want kind=%0d cyc=%0d rf=%0d wb=%0d mem=%0d pc=%h ir=%0d cause=%0d",
                    k, a_cyc, a_rf, a_wbs, a_mc, pc, instret, trap_cause,
                    e.kind, e.cyc, e.rf, e.wbs, e.mc, e.pc, e.ir, e.cause);
            end
            fz_pc = e.pc;
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit closing;
        active = 0;
        term = 0;
        after_rst = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (mem_req || mem_we || ir_we || rf_we || halted || trap) begin
                    errors++;
                    $display("FAIL rst_strobes: got req=%b we=%b ir=%b rf=%b h=%b t=%b want all 0",
                        mem_req, mem_we, ir_we, rf_we, halted, trap);
                end
                active = 0;
                term = 0;
                after_rst = 1;
            end else begin
                if (after_rst) begin
                    after_rst = 0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL rst_state: no expectation queued");
                    end else begin
                        e = q.pop_front();
                        if (e.kind != K_RST || pc !== e.pc || instret !== e.ir
                            || trap_cause !== 2'd0 || mem_req !== 1'b1
                            || mem_addr_sel !== 1'b0 || trap || halted) begin
                            errors++;
                            $display("FAIL rst_state: got pc=%h ir=%0d cause=%0d req=%b sel=%b want pc=%h ir=%0d cause=0 req=1 sel=0 kind=%0d",
                                pc, instret, trap_cause, mem_req, mem_addr_sel,
                                e.pc, e.ir, e.kind);
                        end
                    end
                end
                closing = 0;
                if (active && ir_we) begin
                    close_txn(K_RET);
                    closing = 1;
                    active = 0;
                end else if ((trap || halted) && !term) begin
                    if (!active) begin
                        a_cyc = 0; a_rf = 0; a_wbs = 2'd0; a_mc = 0;
                    end
                    close_txn(halted ? K_HALT : K_TRAP);
                    closing = 1;
                    active = 0;
                    term = 1;
                end
                if (term && !closing) begin
                    checks++;
                    if (pc !== fz_pc || mem_req || ir_we || rf_we
                        || !(trap || halted)) begin
                        errors++;
                        $display("FAIL frozen: got pc=%h req=%b ir=%b rf=%b t=%b h=%b want pc=%h no strobes",
                            pc, mem_req, ir_we, rf_we, trap, halted, fz_pc);
                    end
                end
                if (ir_we) begin
                    active = 1;
                    a_cyc = 0; a_rf = 0; a_wbs = 2'd0; a_mc = 0;
                end
                if (active) begin
                    a_cyc++;
                    if (rf_we) begin
                        a_rf++;
                        a_wbs = wb_sel;
                    end
                    if (mem_req && mem_addr_sel) a_mc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input int k, input int c, input int rf,
                              input logic [1:0] w, input int m,
                              input logic [31:0] p, input logic [31:0] n,
                              input logic [1:0] ca);
        exp_t e;
        e.kind = k; e.cyc = c; e.rf = rf; e.wbs = w; e.mc = m;
        e.pc = p; e.ir = n; e.cause = ca;
        q.push_back(e);
    endtask

    task automatic do_reset(input int n, input logic [31:0] p);
        expect_txn(K_RST, 0, 0, 2'd0, 0, p, 32'd0, 2'd0);
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_fault = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_ready = 1'b0;
        mem_fault = 1'b0;
        repeat (n) step();
    endtask

    task automatic run(input logic [11:0] cls, input int fw, input int dw,
                       input bit ff, input bit df, input bit tk,
                       input logic [31:0] tgt);
        inst_class = cls;
        branch_taken = tk;
        target = tgt;
        mem_ready = 1'b0;
        mem_fault = 1'b0;
        repeat (fw) step();
        mem_ready = 1'b1;
        mem_fault = ff;
        step();
        mem_ready = 1'b0;
        mem_fault = 1'b0;
        if (ff) return;
        step();
        if ($countones(cls) != 1 || cls[10] || cls[11]) return;
        step();
        if (cls[5] || cls[6]) begin
            repeat (dw) step();
            mem_ready = 1'b1;
            mem_fault = df;
            step();
            mem_ready = 1'b0;
            mem_fault = 1'b0;
            if (df || cls[6]) return;
        end
        step();
    endtask

    initial begin : stimulus
        rst = 1'b1;
        inst_class = 12'd0;
        branch_taken = 1'b0;
        target = 32'd0;
        mem_ready = 1'b0;
        mem_fault = 1'b0;
        do_reset(2, 32'h0);

        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h4, 32'd1, 2'd0);
        run(12'h080, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd2, 0, 32'h100, 32'd2, 2'd0);
        run(12'h004, 0, 0, 0, 0, 0, 32'h100);
        expect_txn(K_RET, 4, 0, 2'd0, 0, 32'h104, 32'd3, 2'd0);
        run(12'h010, 0, 0, 0, 0, 0, 32'h200);
        expect_txn(K_RET, 4, 0, 2'd0, 0, 32'h40, 32'd4, 2'd0);
        run(12'h010, 0, 0, 0, 0, 1, 32'h40);
        expect_txn(K_RET, 4, 1, 2'd3, 0, 32'h44, 32'd5, 2'd0);
        run(12'h001, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 8, 1, 2'd1, 4, 32'h48, 32'd6, 2'd0);
        run(12'h020, 0, 3, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 6, 0, 2'd0, 1, 32'h4C, 32'd7, 2'd0);
        run(12'h040, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h50, 32'd8, 2'd0);
        run(12'h002, 2, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h54, 32'd9, 2'd0);
        run(12'h100, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 4, 0, 2'd0, 0, 32'h58, 32'd10, 2'd0);
        run(12'h200, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd2, 0, 32'hFFFF_FFFC, 32'd11, 2'd0);
        run(12'h004, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h0, 32'd12, 2'd0);
        run(12'h080, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_TRAP, 4, 0, 2'd0, 0, 32'h0, 32'd12, 2'd3);
        run(12'h008, 0, 0, 0, 0, 0, 32'h102);
        idle(5);

        do_reset(1, 32'h0);
        expect_txn(K_TRAP, 2, 0, 2'd0, 0, 32'h0, 32'd0, 2'd0);
        run(12'h000, 0, 0, 0, 0, 0, 32'h0);
        idle(3);
        do_reset(1, 32'h0);
        expect_txn(K_TRAP, 2, 0, 2'd0, 0, 32'h0, 32'd0, 2'd0);
        run(12'h030, 0, 0, 0, 0, 0, 32'h0);
        idle(3);
        do_reset(1, 32'h0);
        expect_txn(K_TRAP, 2, 0, 2'd0, 0, 32'h0, 32'd0, 2'd1);
        run(12'h400, 0, 0, 0, 0, 0, 32'h0);
        idle(3);

        do_reset(1, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h4, 32'd1, 2'd0);
        run(12'h080, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_HALT, 2, 0, 2'd0, 0, 32'h4, 32'd1, 2'd0);
        run(12'h800, 0, 0, 0, 0, 0, 32'h0);
        idle(20);

        do_reset(1, 32'h0);
        expect_txn(K_TRAP, 0, 0, 2'd0, 0, 32'h0, 32'd0, 2'd2);
        run(12'h080, 1, 0, 1, 0, 0, 32'h0);
        idle(3);

        do_reset(1, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h4, 32'd1, 2'd0);
        run(12'h080, 0, 0, 0, 0, 0, 32'h0);
        expect_txn(K_TRAP, 6, 0, 2'd0, 3, 32'h4, 32'd1, 2'd2);
        run(12'h020, 0, 2, 0, 1, 0, 32'h0);
        idle(3);

        do_reset(1, 32'h0);
        expect_txn(K_RET, 4, 1, 2'd0, 0, 32'h4, 32'd1, 2'd0);
        run(12'h080, 0, 0, 0, 0, 0, 32'h0);
        inst_class = 12'h020;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        step();
        step();
        step();
        do_reset(1, 32'h0);
        idle(2);

        for (int i = 0; i < 50 && q.size() != 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
